game_ghost_sched: RTL and testbench

Central mode scheduler for all ghosts, replacing the per-ghost copies of the scatter/chase/frighten timers. It is parametrised in ghost count, phase count and every duration. It adds behaviour the per-ghost controllers do not have:
- multi-phase scatter/chase schedule;
- frightened flash warning;
- global freeze while an eaten ghost is scored;
- eaten-ghost score multiplier.

Per-ghost navigation blocks consume its mode/reverse outputs; it sits between the collision logic and the ghosts.

---
 rtl/game_ghost_sched_if.sv | 30 +++
 rtl/game_ghost_sched.sv | 175 +++++++++++++++++
 tb/tb_game_ghost_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/game_ghost_sched_if.sv
// Bundle of control inputs and mode outputs shared between collision logic,
// the ghost scheduler and the per-ghost navigation blocks.
interface game_ghost_sched_if #(
  parameter int NGHOSTS = 4,
  parameter int PW      = 3
);
  logic                   tick;
  logic                   start;
  logic                   restart;
  logic                   power_pellet;
  logic [NGHOSTS-1:0]     ghost_eaten;
  logic [NGHOSTS-1:0]     ghost_home;
  logic [1:0]             glob_mode;
  logic [PW-1:0]          phase;
  logic [2*NGHOSTS-1:0]   ghost_mode;
  logic [NGHOSTS-1:0]     reverse;
  logic                   flash;
  logic                   freeze;
  logic [1:0]             eat_count;
  logic [2*NGHOSTS-1:0]   rand_dir;

  modport master (
    output tick, start, restart, power_pellet, ghost_eaten, ghost_home,
    input  glob_mode, phase, ghost_mode, reverse, flash, freeze, eat_count, rand_dir
  );
  modport slave (
    input  tick, start, restart, power_pellet, ghost_eaten, ghost_home,
    output glob_mode, phase, ghost_mode, reverse, flash, freeze, eat_count, rand_dir
  );
endinterface

// File: rtl/game_ghost_sched.sv
// Central scatter/chase/frighten scheduler for all ghosts, with score freeze
// and eat multiplier. Optional random-direction LFSR: GHOST_SCHED_LFSR_EN.
module game_ghost_sched #(
  parameter int NGHOSTS   = 4,
  parameter int TICK_W    = 11,
  parameter int NPHASES   = 7,
  parameter int SCATTER_T = 420,
  parameter int CHASE_T   = 1200,
  parameter int FRGHT_T   = 600,
  parameter int FLASH_T   = 120,
  parameter int SCORE_T   = 60
) (
  input logic               clk,
  input logic               rst,
  game_ghost_sched_if.slave bus
);
  localparam int PW = $clog2(NPHASES+1);
  localparam logic [1:0] NORM = 2'd0, FRGT = 2'd1, SCOR = 2'd2, DEAD = 2'd3;

  typedef enum logic [1:0] {G_START = 2'd0, G_SCATTER = 2'd1, G_CHASE = 2'd2} gstate_e;

  gstate_e                      st_q, st_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic [TICK_W-1:0]            pt_q, pt_d, ft_q, ft_d, zt_q, zt_d, lim;
  logic                         frz_q, frz_d, flash_q, flash_d;
  logic [1:0]                   eat_q, eat_d;
  logic [NGHOSTS-1:0][1:0]      gm_q, gm_d;
  logic [NGHOSTS-1:0]           rev_q, rev_d, norm_m, frgt_m, frgt_nm, eat_hit, eat_oh;
  logic                         pel, last_phase;

  always_comb begin
    for (int i = 0; i < NGHOSTS; i++) begin
      norm_m[i] = (gm_q[i] == NORM);
      frgt_m[i] = (gm_q[i] == FRGT);
    end
  end

  assign pel        = bus.power_pellet && (st_q != G_START) && !frz_q;
  assign lim        = (st_q == G_CHASE) ? TICK_W'(CHASE_T) : TICK_W'(SCATTER_T);
  assign last_phase = (phase_q == PW'(NPHASES));
  assign eat_hit    = bus.ghost_eaten & frgt_m;
  assign eat_oh     = eat_hit & (~eat_hit + NGHOSTS'(1));

  always_comb begin
    st_d    = st_q;
    phase_d = phase_q;
    pt_d    = pt_q;
    ft_d    = ft_q;
    zt_d    = zt_q;
    frz_d   = frz_q;
    eat_d   = eat_q;
    gm_d    = gm_q;
    rev_d   = '0;

    // Phase schedule pauses during fright, freeze and the pellet cycle itself.
    if (st_q == G_START) begin
      if (bus.start) st_d = G_SCATTER;
    end else if (bus.tick && !last_phase && !(|frgt_m) && !frz_q && !pel) begin
      if (pt_q == lim - TICK_W'(1)) begin
        pt_d    = '0;
        phase_d = phase_q + PW'(1);
        st_d    = ((phase_q + PW'(1)) == PW'(NPHASES) || st_q == G_SCATTER) ? G_CHASE : G_SCATTER;
        rev_d   = norm_m;
      end else begin
        pt_d = pt_q + TICK_W'(1);
      end
    end

    if (pel) begin
      ft_d  = TICK_W'(FRGHT_T);
      eat_d = 2'd0;
      for (int i = 0; i < NGHOSTS; i++)
        if (norm_m[i] || frgt_m[i]) begin
          gm_d[i]  = FRGT;
          rev_d[i] = 1'b1;
        end
    end else begin
      if (bus.tick && ft_q != '0 && !frz_q) begin
        ft_d = ft_q - TICK_W'(1);
        if (ft_q == TICK_W'(1))
          for (int i = 0; i < NGHOSTS; i++)
            if (frgt_m[i]) gm_d[i] = NORM;
      end
      if (!frz_q && |eat_oh) begin
        for (int i = 0; i < NGHOSTS; i++)
          if (eat_oh[i]) gm_d[i] = SCOR;
        frz_d = 1'b1;
        zt_d  = TICK_W'(SCORE_T);
        eat_d = (eat_q == 2'd3) ? 2'd3 : eat_q + 2'd1;
      end
    end

    if (frz_q && bus.tick) begin
      zt_d = zt_q - TICK_W'(1);
      if (zt_q == TICK_W'(1)) begin
        frz_d = 1'b0;
        for (int i = 0; i < NGHOSTS; i++)
          if (gm_q[i] == SCOR) gm_d[i] = DEAD;
      end
    end

    for (int i = 0; i < NGHOSTS; i++)
      if (gm_q[i] == DEAD && bus.ghost_home[i]) gm_d[i] = NORM;

    rev_d = rev_d & ~rev_q;

    if (bus.restart) begin
      st_d    = G_START;
      phase_d = '0;
      pt_d    = '0;
      ft_d    = '0;
      zt_d    = '0;
      frz_d   = 1'b0;
      eat_d   = 2'd0;
      gm_d    = '0;
      rev_d   = '0;
    end

    for (int i = 0; i < NGHOSTS; i++) frgt_nm[i] = (gm_d[i] == FRGT);
    flash_d = (ft_d != '0) && (ft_d <= TICK_W'(FLASH_T)) && (|frgt_nm);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= G_START;
      phase_q <= '0;
      pt_q    <= '0;
      ft_q    <= '0;
      zt_q    <= '0;
      frz_q   <= 1'b0;
      flash_q <= 1'b0;
      eat_q   <= 2'd0;
      gm_q    <= '0;
      rev_q   <= '0;
    end else begin
      st_q    <= st_d;
      phase_q <= phase_d;
      pt_q    <= pt_d;
      ft_q    <= ft_d;
      zt_q    <= zt_d;
      frz_q   <= frz_d;
      flash_q <= flash_d;
      eat_q   <= eat_d;
      gm_q    <= gm_d;
      rev_q   <= rev_d;
    end
  end

  assign bus.glob_mode  = st_q;
  assign bus.phase      = phase_q;
  assign bus.ghost_mode = gm_q;
  assign bus.reverse    = rev_q;
  assign bus.flash      = flash_q;
  assign bus.freeze     = frz_q;
  assign bus.eat_count  = eat_q;

`ifdef GHOST_SCHED_LFSR_EN
  logic [15:0]          lfsr_q;
  logic [2*NGHOSTS-1:0] rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             lfsr_q <= 16'hACE1;
    else if (bus.restart) lfsr_q <= 16'hACE1;
    else if (bus.tick)    lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NGHOSTS; i++) rd[2*i +: 2] = lfsr_q[(2*i) % 16 +: 2];
  end
  assign bus.rand_dir = rd;
`else
  assign bus.rand_dir = '0;
`endif
endmodule

// File: tb/tb_game_ghost_sched.sv
// Directed self-checking bench for game_ghost_sched (default build, 4 ghosts).
module tb_game_ghost_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  game_ghost_sched_if #(.NGHOSTS(4), .PW(3)) b();
  game_ghost_sched dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    b.tick = 1'b1;
    repeat (n) cyc();
    b.tick = 1'b0;
  endtask

  initial begin
    b.tick = 0; b.start = 0; b.restart = 0; b.power_pellet = 0;
    b.ghost_eaten = '0; b.ghost_home = '0;
    repeat (3) cyc();
    chk("rst_glob", b.glob_mode, 0);
    chk("rst_phase", b.phase, 0);
    chk("rst_gmode", b.ghost_mode, 0);
    chk("rst_rev", b.reverse, 0);
    chk("rst_flash", b.flash, 0);
    chk("rst_freeze", b.freeze, 0);
    chk("rst_eat", b.eat_count, 0);
    chk("rst_rand", b.rand_dir, 0);
    rst = 1'b1;
    cyc();

    // 1: schedule
    ticks(5);
    chk("start_ign_tick", b.glob_mode, 0);
    b.start = 1; cyc(); b.start = 0;
    chk("t1_scatter", b.glob_mode, 1);
    ticks(419);
    chk("t1_pre_glob", b.glob_mode, 1);
    chk("t1_pre_phase", b.phase, 0);
    ticks(1);
    chk("t1_chase", b.glob_mode, 2);
    chk("t1_phase1", b.phase, 1);
    chk("t1_rev", b.reverse, 4'hF);
    cyc();
    chk("t1_rev_off", b.reverse, 0);
    ticks(1200);
    chk("t1_scatter2", b.glob_mode, 1);
    chk("t1_phase2", b.phase, 2);

    // 2: fright and flash
    ticks(100);
    b.power_pellet = 1; cyc(); b.power_pellet = 0;
    chk("t2_frgt", b.ghost_mode, 8'h55);
    chk("t2_rev", b.reverse, 4'hF);
    cyc();
    chk("t2_rev_off", b.reverse, 0);
    ticks(479);
    chk("t2_noflash", b.flash, 0);
    ticks(1);
    chk("t2_flash", b.flash, 1);
    ticks(119);
    chk("t2_still_frgt", b.ghost_mode, 8'h55);
    ticks(1);
    chk("t2_norm", b.ghost_mode, 0);
    chk("t2_flash_off", b.flash, 0);
    chk("t2_norev", b.reverse, 0);
    ticks(319);
    chk("t2_held_phase", b.phase, 2);
    ticks(1);
    chk("t2_exp_glob", b.glob_mode, 2);
    chk("t2_exp_phase", b.phase, 3);

    // 3: eat one ghost, lowest index wins
    b.power_pellet = 1; cyc(); b.power_pellet = 0;
    cyc();
    b.ghost_eaten = 4'b0110; cyc(); b.ghost_eaten = '0;
    chk("t3_scor", b.ghost_mode, 8'h59);
    chk("t3_eat", b.eat_count, 1);
    chk("t3_freeze", b.freeze, 1);
    ticks(59);
    chk("t3_freeze_hold", b.freeze, 1);
    ticks(1);
    chk("t3_unfreeze", b.freeze, 0);
    chk("t3_dead", b.ghost_mode, 8'h5D);
    b.ghost_home = 4'b0010; cyc(); b.ghost_home = '0;
    chk("t3_home", b.ghost_mode, 8'h51);
    b.ghost_eaten = 4'b0010; cyc(); b.ghost_eaten = '0;
    chk("t3_ign_norm", b.ghost_mode, 8'h51);
    chk("t3_ign_frz", b.freeze, 0);

    // 4: four eats, saturation, fright frozen during freeze
    b.power_pellet = 1; cyc(); b.power_pellet = 0;
    chk("t4_repel", b.ghost_mode, 8'h55);
    chk("t4_eat0", b.eat_count, 0);
    b.ghost_eaten = 4'b0001; cyc(); b.ghost_eaten = '0;
    chk("t4_e1", b.eat_count, 1);
    chk("t4_m1", b.ghost_mode, 8'h56);
    ticks(60);
    b.ghost_eaten = 4'b0010; cyc(); b.ghost_eaten = '0;
    chk("t4_e2", b.eat_count, 2);
    chk("t4_m2", b.ghost_mode, 8'h5B);
    ticks(60);
    b.ghost_eaten = 4'b0100; cyc(); b.ghost_eaten = '0;
    chk("t4_e3", b.eat_count, 3);
    ticks(60);
    chk("t4_m3", b.ghost_mode, 8'h7F);
    ticks(479);
    chk("t4_noflash", b.flash, 0);
    ticks(1);
    chk("t4_flash", b.flash, 1);
    b.ghost_eaten = 4'b1000; cyc(); b.ghost_eaten = '0;
    chk("t4_e4_sat", b.eat_count, 3);
    chk("t4_m4", b.ghost_mode, 8'hBF);
    chk("t4_flash_none", b.flash, 0);
    ticks(60);
    chk("t4_alldead", b.ghost_mode, 8'hFF);
    b.ghost_home = 4'hF; cyc(); b.ghost_home = '0;
    chk("t4_allhome", b.ghost_mode, 0);
    ticks(120);

    // 5: pellet beats eat; pellet ignored during freeze
    b.power_pellet = 1; b.ghost_eaten = 4'b0001; cyc();
    b.power_pellet = 0; b.ghost_eaten = '0;
    chk("t5_mode", b.ghost_mode, 8'h55);
    chk("t5_eat", b.eat_count, 0);
    chk("t5_freeze", b.freeze, 0);
    cyc();
    b.ghost_eaten = 4'b0001; cyc(); b.ghost_eaten = '0;
    b.power_pellet = 1; cyc(); b.power_pellet = 0;
    chk("t5_frz_pel_mode", b.ghost_mode, 8'h56);
    chk("t5_frz_pel_eat", b.eat_count, 1);
    chk("t5_frz_pel_rev", b.reverse, 0);

    // 6: async reset mid-freeze, then restart from chase phase 5
    rst = 1'b0; #1;
    chk("t6_glob", b.glob_mode, 0);
    chk("t6_mode", b.ghost_mode, 0);
    chk("t6_freeze", b.freeze, 0);
    chk("t6_eat", b.eat_count, 0);
    cyc();
    rst = 1'b1;
    cyc();
    b.start = 1; cyc(); b.start = 0;
    ticks(420); ticks(1200); ticks(420); ticks(1200); ticks(420);
    chk("t6_ph5_glob", b.glob_mode, 2);
    chk("t6_ph5", b.phase, 5);
    ticks(50);
    b.restart = 1; b.start = 1; cyc(); b.restart = 0; b.start = 0;
    chk("t6_rs_glob", b.glob_mode, 0);
    chk("t6_rs_phase", b.phase, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
